// File: rtl/column_dropper.sv
// Column drop controller: animates a token falling down one Connect Four
// column and issues a single-cycle placement code to the landing cell.
module column_dropper #(
    parameter int ROWS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                drop,
    input  logic [1:0]          player,
    input  logic                tick,
    input  logic [2*ROWS-1:0]   cell_state,
    output logic [2*ROWS-1:0]   up,
    output logic [ROWS-1:0]     falling,
    output logic                busy,
    output logic                done,
    output logic                rejected
);

    localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FALL,
        PLACE,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   pos;
    logic [PW-1:0]   pos_next;
    logic [1:0]      color;
    logic [1:0]      color_next;
    logic            rejected_next;
    logic            player_valid;
    logic            top_empty;
    logic            at_bottom;
    logic            below_occupied;

    assign player_valid = (player == 2'b10) || (player == 2'b01);
    assign top_empty    = (cell_state[1:0] == 2'b00);
    assign at_bottom    = (pos == PW'(ROWS - 1));

    // Occupancy of the row directly beneath the falling token.
    always_comb begin
        below_occupied = 1'b0;
        for (int r = 0; r < ROWS - 1; r++) begin
            if (pos == PW'(r)) begin
                below_occupied = |cell_state[2*(r+1) +: 2];
            end
        end
    end

    // State, position, color and the registered reject pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            pos      <= '0;
            color    <= 2'b00;
            rejected <= 1'b0;
        end else begin
            state    <= state_next;
            pos      <= pos_next;
            color    <= color_next;
            rejected <= rejected_next;
        end
    end

    // Next-state logic: accept or refuse drops, step on ticks, land.
    always_comb begin
        state_next    = state;
        pos_next      = pos;
        color_next    = color;
        rejected_next = 1'b0;
        case (state)
            IDLE: begin
                if (drop) begin
                    if (player_valid && top_empty) begin
                        state_next = FALL;
                        pos_next   = '0;
                        color_next = player;
                    end else begin
                        rejected_next = 1'b1;
                    end
                end
            end
            FALL: begin
                if (tick) begin
                    if (at_bottom || below_occupied) begin
                        state_next = PLACE;
                    end else begin
                        pos_next = pos + 1'b1;
                    end
                end
            end
            PLACE: begin
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        up      = '0;
        falling = '0;
        busy    = (state != IDLE);
        done    = (state == DONE);
        if (state == FALL || state == PLACE) begin
            falling[pos] = 1'b1;
        end
        if (state == PLACE) begin
            for (int r = 0; r < ROWS; r++) begin
                if (pos == PW'(r)) begin
                    up[2*r +: 2] = color;
                end
            end
        end
    end

endmodule

// File: doc/column_dropper.md
Name: column_dropper

Overview:
Per-column drop controller for the Connect Four board; it drives the `up` inputs of the column's stack of cell light modules. On a player's drop command it animates the token falling from the top row, one row per animation tick. It stops on the lowest empty cell and issues a one-cycle placement code to that cell's `up` input. It also reports busy, done and rejected status to the game controller.

Parameters:
ROWS, 8, number of cells in the column; row 0 = top, row ROWS-1 = bottom.

Ports:
clock  input  1  system clock.
reset  input  1  synchronous, active-high reset.
drop  input  1  one-cycle drop request from game controller.
player  input  2  color of token being dropped: 2'b10 green, 2'b01 red; 2'b00/2'b11 invalid.
tick  input  1  animation step enable; token advances at most one row per tick cycle.
cell_state  input  2*ROWS  current light output of each cell; bits [2r+1:2r] = row r; 2'b00 = empty.
up  output  2*ROWS  placement code to each cell; bits [2r+1:2r] = row r.
falling  output  ROWS  one-hot position of the animated falling token; bit r = row r.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse after placement completes.
rejected  output  1  one-cycle pulse when a drop is refused.

Behaviour:
- Moore FSM with states IDLE, FALL, PLACE, DONE; registers: state, pos (clog2(ROWS) bits), color (2 bits).
- Reset, including mid-operation: state=IDLE, pos=0, color=00. All outputs 0 in the cycle after the reset edge.
- A token in flight at reset is discarded; no `up` code is issued for it.
- IDLE, drop=1, player is 2'b10 or 2'b01, row 0 empty (cell_state[1:0]==00): latch color=player, pos=0, next state FALL.
- IDLE, drop=1, player invalid: rejected=1 next cycle, stay IDLE.
- IDLE, drop=1, row 0 occupied (column full): rejected=1 next cycle, stay IDLE.
- rejected is registered: it is high for exactly the one cycle following the refused request.
- drop while busy: ignored; no rejected, no state change.
- FALL:
  - falling = one-hot(pos); up = all 0.
  - On a tick cycle: if pos==ROWS-1, or row pos+1 is non-empty, next state PLACE with pos held.
  - Otherwise on a tick cycle, pos <= pos+1.
  - tick=0: hold.
- The landing decision uses cell_state sampled in the tick cycle. Only row pos+1 is examined.
- PLACE:
  - Lasts exactly one cycle; up[2*pos+1:2*pos] = color, all other up bits 0; falling = one-hot(pos).
  - Next state DONE. The cell latches the code on the following edge.
- DONE: done=1, up=0, falling=0, for one cycle; next state IDLE.
- In DONE, cell_state for the landing row already shows color.
- busy=1 in FALL, PLACE and DONE.
- A new drop is accepted in the first IDLE cycle after DONE.
- up is nonzero only in PLACE, and only for one row. Never drive 2'b11.
- Latency, tick held high, empty column, drop accepted at edge 0:
  - FALL occupies 8 cycles (pos 0..7).
  - PLACE is at cycle 9 and done=1 at cycle 10.
  - General case: FALL length = landing row + 1 ticks.
- With row 1 occupied: lands in row 0 after 1 tick. This fills the column; the next drop is rejected.

Test Plan:
1. Reset, cell_state=0, tick=1, drop with player=10 → falling walks 0x01..0x80 over 8 cycles. Then PLACE with up[15:14]=10, all else 0, for one cycle, then a single done pulse; busy high throughout.
2. cell_state rows 7,6 occupied, drop player=01, tick every 3rd cycle → token stops at pos 5; up[11:10]=01 for one cycle; done follows; exactly 6 ticks are consumed.
3. Row 0 occupied, drop player=10 → rejected=1 for one cycle; busy, up and falling stay 0.
4. Drop with player=00, then with player=11 → rejected pulses each time; no state change.
5. Drop accepted, second drop issued during FALL → ignored: no rejected, only one placement and one done.
6. Reset asserted at pos=3 mid-fall → next cycle all outputs 0, state IDLE, no up code ever issued; a subsequent drop behaves as in scenario 1.
